// File: rtl/gc_flush_ctrl.sv
// -----------------------------------------------------------------------------
// gc_flush_ctrl
// Global-control sequencer for the core. It arbitrates NUM_SRC exception
// sources against the oldest in-flight instruction ID. It serialises FENCE.I,
// MRET/SRET and interrupts through DRAIN -> FLUSH -> DISCARD. It also runs
// the initial (and on-demand) CLEAR sweep.
//
// Ports
//   clk, rst                clock; asynchronous active-low reset
//   issue_*                 issued-instruction info (valid, ifence, ret, pc+4)
//   ret_epc, trap_target_pc redirect targets supplied by the CSR block
//   exc_valid/id/code       per-source exceptions, flattened source-major
//   oldest_id               ID of the next instruction to retire
//   interrupt_pending       enabled interrupt waiting to be taken
//   inflight_count, sq_empty  back-end occupancy, used for quiescence
//   reclear_req             full re-initialisation request (honoured in IDLE)
//   fetch_hold .. pc_override  registered pipeline controls
//   pc                      registered override target
//   exc_ack, trap_valid, trap_code  combinational exception arbitration result
//   interrupt_taken, ret_taken      one-cycle pulses, aligned with FLUSH
//   drain_timeout           sticky watchdog flag
// -----------------------------------------------------------------------------
module gc_flush_ctrl #(
  parameter int          NUM_SRC       = 4,
  parameter int          ID_W          = 3,
  parameter int          CODE_W        = 5,
  parameter int          CLEAR_DEPTH   = 64,
  parameter int          DRAIN_TIMEOUT = 1024,
  parameter logic [31:0] RESET_VEC     = 32'h8000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic                       issue_is_ifence,
  input  logic                       issue_is_ret,
  input  logic [31:0]                issue_pc_p4,
  input  logic [31:0]                ret_epc,
  input  logic [31:0]                trap_target_pc,
  input  logic [NUM_SRC-1:0]         exc_valid,
  input  logic [NUM_SRC*ID_W-1:0]    exc_id,
  input  logic [NUM_SRC*CODE_W-1:0]  exc_code,
  input  logic [ID_W-1:0]            oldest_id,
  input  logic                       interrupt_pending,
  input  logic [ID_W:0]              inflight_count,
  input  logic                       sq_empty,
  input  logic                       reclear_req,
  output logic                       fetch_hold,
  output logic                       issue_hold,
  output logic                       retire_hold,
  output logic                       wb_suppress,
  output logic                       init_clear,
  output logic                       pc_override,
  output logic [31:0]                pc,
  output logic [NUM_SRC-1:0]         exc_ack,
  output logic                       trap_valid,
  output logic [CODE_W-1:0]          trap_code,
  output logic                       interrupt_taken,
  output logic                       ret_taken,
  output logic                       drain_timeout
);

  localparam logic [2:0] S_RESET   = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_IDLE    = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;
  localparam logic [2:0] S_DISCARD = 3'd5;

  localparam int               CLR_W    = $clog2(CLEAR_DEPTH);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_DEPTH - 1);
  localparam logic [CLR_W-1:0] CLR_ONE  = CLR_W'(1);

  // Wide enough to hold DRAIN_TIMEOUT itself (and at least one bit when the
  // watchdog is disabled).
  localparam int              WD_W     = $clog2(DRAIN_TIMEOUT + 2);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(DRAIN_TIMEOUT);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  logic [2:0]       state_q, state_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             op_ifence_q, op_ifence_d;
  logic             op_ret_q, op_ret_d;
  logic [31:0]      pc_p4_q, pc_p4_d;
  logic [31:0]      pc_q, pc_d;
  logic             fetch_hold_q, fetch_hold_d;
  logic             issue_hold_q, issue_hold_d;
  logic             retire_hold_q, retire_hold_d;
  logic             wb_suppress_q, wb_suppress_d;
  logic             init_clear_q, init_clear_d;
  logic             pc_override_q, pc_override_d;
  logic             interrupt_taken_q, interrupt_taken_d;
  logic             ret_taken_q, ret_taken_d;
  logic             drain_timeout_q, drain_timeout_d;

  // ---------------------------------------------------------------------------
  // Exception arbitration: lowest matching source index wins.
  // lower_any[i] is set when any source below i matches, which turns the
  // match vector into a one-hot winner without a priority encoder.
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] match;
  logic [NUM_SRC:0]   lower_any;
  logic [NUM_SRC-1:0] win;
  logic [CODE_W-1:0]  code_sel;
  logic               any_match;
  logic               arb_state;

  assign lower_any[0] = 1'b0;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_match
    assign match[gi]       = exc_valid[gi] && (exc_id[gi*ID_W +: ID_W] == oldest_id);
    assign win[gi]         = match[gi] && !lower_any[gi];
    assign lower_any[gi+1] = lower_any[gi] | match[gi];
  end

  always_comb begin
    code_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win[i]) begin
        code_sel = code_sel | exc_code[i*CODE_W +: CODE_W];
      end
    end
  end

  assign any_match  = lower_any[NUM_SRC];
  assign arb_state  = (state_q == S_IDLE) || (state_q == S_DRAIN);
  assign trap_valid = any_match && arb_state;
  assign exc_ack    = trap_valid ? win : '0;
  assign trap_code  = trap_valid ? code_sel : '0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic op_pending;
  logic quiet;
  logic enter_flush;

  assign op_pending = op_ifence_q | op_ret_q;
  assign quiet      = (inflight_count == '0) && sq_empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_CLEAR;
      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (trap_valid) begin
          state_d = S_FLUSH;
        end else if (reclear_req) begin
          state_d = S_CLEAR;
        end else if ((issue_valid && (issue_is_ifence || issue_is_ret)) ||
                     interrupt_pending || (|exc_valid)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (trap_valid) begin
          state_d = S_FLUSH;
        end else if (op_pending && quiet) begin
          state_d = S_FLUSH;
        end else if (interrupt_pending && (inflight_count == '0)) begin
          state_d = S_FLUSH;
        end else if (!op_pending && !interrupt_pending && !(|exc_valid)) begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH:   state_d = S_DISCARD;
      S_DISCARD: begin
        if (quiet) state_d = S_IDLE;
      end
      default:   state_d = S_RESET;
    endcase
  end

  assign enter_flush = (state_d == S_FLUSH);

  // ---------------------------------------------------------------------------
  // Counters, latched op, redirect target
  // ---------------------------------------------------------------------------
  always_comb begin
    // CLEAR sweep index: starts at 0 on entry, last value is CLR_LAST.
    clr_cnt_d = '0;
    if (state_d == S_CLEAR && state_q == S_CLEAR) begin
      clr_cnt_d = clr_cnt_q + CLR_ONE;
    end

    // wd_cnt_d is the 1-based number of the DRAIN cycle about to start, so
    // the flag registered alongside it is visible in that very cycle.
    wd_cnt_d = '0;
    if (state_d == S_DRAIN) begin
      if (state_q != S_DRAIN) begin
        wd_cnt_d = WD_ONE;
      end else if (wd_cnt_q != WD_LIMIT) begin
        wd_cnt_d = wd_cnt_q + WD_ONE;
      end else begin
        wd_cnt_d = wd_cnt_q;
      end
    end

    drain_timeout_d = drain_timeout_q;
    if (state_d == S_CLEAR) begin
      drain_timeout_d = 1'b0;
    end else if ((DRAIN_TIMEOUT != 0) && (state_d == S_DRAIN) && (wd_cnt_d == WD_LIMIT)) begin
      drain_timeout_d = 1'b1;
    end

    op_ifence_d = op_ifence_q;
    op_ret_d    = op_ret_q;
    pc_p4_d     = pc_p4_q;
    if (state_q == S_IDLE && issue_valid) begin
      op_ifence_d = issue_is_ifence;
      op_ret_d    = issue_is_ret;
      pc_p4_d     = issue_pc_p4;
    end
    // The op is consumed by the flush (or abandoned by a re-clear).
    if (state_d == S_FLUSH || state_d == S_CLEAR) begin
      op_ifence_d = 1'b0;
      op_ret_d    = 1'b0;
    end

    // Trap kind priority: exception > op > interrupt. If both op bits are
    // somehow set, ret is treated as the op that redirects.
    pc_d              = pc_q;
    ret_taken_d       = 1'b0;
    interrupt_taken_d = 1'b0;
    if (state_d == S_CLEAR) begin
      pc_d = RESET_VEC;
    end else if (enter_flush) begin
      if (trap_valid) begin
        pc_d = trap_target_pc;
      end else if (op_ret_q) begin
        pc_d        = ret_epc;
        ret_taken_d = 1'b1;
      end else if (op_ifence_q) begin
        pc_d = pc_p4_q;
      end else begin
        pc_d              = trap_target_pc;
        interrupt_taken_d = interrupt_pending;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline controls, registered from the next state
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_hold_d  = (state_d == S_CLEAR) || (state_d == S_DRAIN) || (state_d == S_FLUSH);
    issue_hold_d  = (state_d == S_CLEAR) || (state_d == S_DRAIN) ||
                    (state_d == S_FLUSH) || (state_d == S_DISCARD);
    retire_hold_d = (state_d == S_FLUSH);
    wb_suppress_d = (state_d == S_CLEAR) || (state_d == S_DISCARD);
    init_clear_d  = (state_d == S_CLEAR);
    // The redirect to RESET_VEC is issued in the last sweep cycle so fetch
    // restarts the moment the holds drop.
    pc_override_d = (state_d == S_FLUSH) ||
                    ((state_d == S_CLEAR) && (clr_cnt_d == CLR_LAST));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= S_RESET;
      clr_cnt_q         <= '0;
      wd_cnt_q          <= '0;
      op_ifence_q       <= 1'b0;
      op_ret_q          <= 1'b0;
      pc_p4_q           <= '0;
      pc_q              <= RESET_VEC;
      fetch_hold_q      <= 1'b0;
      issue_hold_q      <= 1'b0;
      retire_hold_q     <= 1'b0;
      wb_suppress_q     <= 1'b0;
      init_clear_q      <= 1'b0;
      pc_override_q     <= 1'b0;
      interrupt_taken_q <= 1'b0;
      ret_taken_q       <= 1'b0;
      drain_timeout_q   <= 1'b0;
    end else begin
      state_q           <= state_d;
      clr_cnt_q         <= clr_cnt_d;
      wd_cnt_q          <= wd_cnt_d;
      op_ifence_q       <= op_ifence_d;
      op_ret_q          <= op_ret_d;
      pc_p4_q           <= pc_p4_d;
      pc_q              <= pc_d;
      fetch_hold_q      <= fetch_hold_d;
      issue_hold_q      <= issue_hold_d;
      retire_hold_q     <= retire_hold_d;
      wb_suppress_q     <= wb_suppress_d;
      init_clear_q      <= init_clear_d;
      pc_override_q     <= pc_override_d;
      interrupt_taken_q <= interrupt_taken_d;
      ret_taken_q       <= ret_taken_d;
      drain_timeout_q   <= drain_timeout_d;
    end
  end

  assign fetch_hold      = fetch_hold_q;
  assign issue_hold      = issue_hold_q;
  assign retire_hold     = retire_hold_q;
  assign wb_suppress     = wb_suppress_q;
  assign init_clear      = init_clear_q;
  assign pc_override     = pc_override_q;
  assign pc              = pc_q;
  assign interrupt_taken = interrupt_taken_q;
  assign ret_taken       = ret_taken_q;
  assign drain_timeout   = drain_timeout_q;

endmodule

// File: tb/tb_gc_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gc_flush_ctrl
// Directed bench for gc_flush_ctrl (4 sources, CLEAR_DEPTH 64, DRAIN_TIMEOUT
// 16). Inputs change 1 ns after the rising edge and outputs are checked there
// too, away from the active edge.
// -----------------------------------------------------------------------------
module tb_gc_flush_ctrl;

  localparam int          NUM_SRC = 4;
  localparam int          ID_W    = 3;
  localparam int          CODE_W  = 5;
  localparam logic [31:0] RV      = 32'h8000_0000;
  localparam logic [31:0] TRAP_PC = 32'h0000_0100;
  localparam logic [31:0] EPC     = 32'h0000_2000;

  logic                      clk;
  logic                      rst;
  logic                      issue_valid;
  logic                      issue_is_ifence;
  logic                      issue_is_ret;
  logic [31:0]               issue_pc_p4;
  logic [31:0]               ret_epc;
  logic [31:0]               trap_target_pc;
  logic [NUM_SRC-1:0]        exc_valid;
  logic [NUM_SRC*ID_W-1:0]   exc_id;
  logic [NUM_SRC*CODE_W-1:0] exc_code;
  logic [ID_W-1:0]           oldest_id;
  logic                      interrupt_pending;
  logic [ID_W:0]             inflight_count;
  logic                      sq_empty;
  logic                      reclear_req;
  logic                      fetch_hold, issue_hold, retire_hold, wb_suppress;
  logic                      init_clear, pc_override;
  logic [31:0]               pc;
  logic [NUM_SRC-1:0]        exc_ack;
  logic                      trap_valid;
  logic [CODE_W-1:0]         trap_code;
  logic                      interrupt_taken, ret_taken, drain_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  gc_flush_ctrl #(
    .NUM_SRC(NUM_SRC), .ID_W(ID_W), .CODE_W(CODE_W),
    .CLEAR_DEPTH(64), .DRAIN_TIMEOUT(16), .RESET_VEC(RV)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_is_ifence(issue_is_ifence),
    .issue_is_ret(issue_is_ret), .issue_pc_p4(issue_pc_p4),
    .ret_epc(ret_epc), .trap_target_pc(trap_target_pc),
    .exc_valid(exc_valid), .exc_id(exc_id), .exc_code(exc_code),
    .oldest_id(oldest_id), .interrupt_pending(interrupt_pending),
    .inflight_count(inflight_count), .sq_empty(sq_empty),
    .reclear_req(reclear_req),
    .fetch_hold(fetch_hold), .issue_hold(issue_hold), .retire_hold(retire_hold),
    .wb_suppress(wb_suppress), .init_clear(init_clear), .pc_override(pc_override),
    .pc(pc), .exc_ack(exc_ack), .trap_valid(trap_valid), .trap_code(trap_code),
    .interrupt_taken(interrupt_taken), .ret_taken(ret_taken),
    .drain_timeout(drain_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs the 64-cycle sweep from the cycle before CLEAR is entered through
  // to IDLE. Also drops reclear_req after the entry edge.
  task automatic clear_seq(input string tag);
    int ic;
    ic = 0;
    for (int k = 1; k <= 65; k++) begin
      tick();
      reclear_req = 1'b0;
      ic += int'(init_clear);
      if (k == 1) begin
        chk({tag, "_wb_supp"}, wb_suppress, 1);
        chk({tag, "_fetch_hold"}, fetch_hold, 1);
        chk({tag, "_dt_clr"}, drain_timeout, 0);
      end
      if (k == 63) chk({tag, "_pco_early"}, pc_override, 0);
      if (k == 64) begin
        chk({tag, "_pco_last"}, pc_override, 1);
        chk({tag, "_pc_rv"}, pc, RV);
      end
    end
    chk({tag, "_ic_cycles"}, ic, 64);
    chk({tag, "_ic_off"}, init_clear, 0);
    chk({tag, "_pco_off"}, pc_override, 0);
    chk({tag, "_idle_issue"}, issue_hold, 0);
  endtask

  initial begin
    rst               = 1'b0;
    issue_valid       = 1'b0;
    issue_is_ifence   = 1'b0;
    issue_is_ret      = 1'b0;
    issue_pc_p4       = '0;
    ret_epc           = EPC;
    trap_target_pc    = TRAP_PC;
    exc_valid         = '0;
    exc_id            = {3'd0, 3'd3, 3'd3, 3'd1};
    exc_code          = {5'd0, 5'd7, 5'd2, 5'd0};
    oldest_id         = 3'd3;
    interrupt_pending = 1'b0;
    inflight_count    = '0;
    sq_empty          = 1'b1;
    reclear_req       = 1'b0;

    // ---- reset state
    tick(); tick();
    chk("rst_fetch", fetch_hold, 0);
    chk("rst_issue", issue_hold, 0);
    chk("rst_init", init_clear, 0);
    chk("rst_pco", pc_override, 0);
    chk("rst_pc", pc, RV);
    chk("rst_dt", drain_timeout, 0);
    rst = 1'b1;
    clear_seq("boot");

    // ---- two sources match, lowest index wins
    exc_valid = 4'b0110;
    #1;
    chk("exc_tv", trap_valid, 1);
    chk("exc_ack", exc_ack, 4'b0010);
    chk("exc_code", trap_code, 2);
    tick();
    chk("exc_flush_rh", retire_hold, 1);
    chk("exc_flush_pco", pc_override, 1);
    chk("exc_flush_pc", pc, TRAP_PC);
    chk("exc_flush_tv_off", trap_valid, 0);
    chk("exc_flush_ack_off", exc_ack, 0);
    exc_valid = '0;
    tick();
    chk("exc_disc_wb", wb_suppress, 1);
    chk("exc_disc_issue", issue_hold, 1);
    chk("exc_disc_fetch", fetch_hold, 0);
    chk("exc_disc_rh", retire_hold, 0);
    tick();
    chk("exc_idle_issue", issue_hold, 0);

    // ---- non-oldest exception drains, then wins once it becomes oldest
    exc_valid = 4'b0001;
    #1;
    chk("nold_tv", trap_valid, 0);
    tick();
    chk("nold_drain_fetch", fetch_hold, 1);
    oldest_id = 3'd1;
    #1;
    chk("nold_tv_now", trap_valid, 1);
    chk("nold_ack", exc_ack, 4'b0001);
    chk("nold_code", trap_code, 0);
    tick();
    chk("nold_flush_rh", retire_hold, 1);
    exc_valid = '0;
    oldest_id = 3'd3;
    tick(); tick();
    chk("nold_idle", issue_hold, 0);

    // ---- FENCE.I drains as inflight falls, then waits for the store queue
    issue_valid = 1'b1; issue_is_ifence = 1'b1; issue_pc_p4 = 32'h104;
    inflight_count = 4'd3;
    tick();
    chk("ifn_c1_fetch", fetch_hold, 1);
    chk("ifn_c1_issue", issue_hold, 1);
    issue_valid = 1'b0; issue_is_ifence = 1'b0;
    inflight_count = 4'd2; tick();
    inflight_count = 4'd1; tick();
    chk("ifn_c3_fetch", fetch_hold, 1);
    inflight_count = 4'd0; sq_empty = 1'b0; tick();
    chk("ifn_sq_fetch", fetch_hold, 1);
    chk("ifn_sq_rh", retire_hold, 0);
    sq_empty = 1'b1; tick();
    chk("ifn_flush_pc", pc, 32'h104);
    chk("ifn_flush_pco", pc_override, 1);
    chk("ifn_flush_irq", interrupt_taken, 0);
    chk("ifn_flush_ret", ret_taken, 0);
    tick(); tick();
    chk("ifn_idle", issue_hold, 0);

    // ---- ret beats a concurrent interrupt; interrupt taken afterwards
    issue_valid = 1'b1; issue_is_ret = 1'b1; issue_pc_p4 = 32'h300;
    interrupt_pending = 1'b1;
    tick();
    chk("ret_drain_fetch", fetch_hold, 1);
    issue_valid = 1'b0; issue_is_ret = 1'b0;
    tick();
    chk("ret_taken", ret_taken, 1);
    chk("ret_irq_off", interrupt_taken, 0);
    chk("ret_pc", pc, EPC);
    tick();
    chk("ret_pulse_end", ret_taken, 0);
    tick();
    chk("ret_idle", issue_hold, 0);
    tick();
    chk("irq_drain", fetch_hold, 1);
    tick();
    chk("irq_taken", interrupt_taken, 1);
    chk("irq_ret_off", ret_taken, 0);
    chk("irq_pc", pc, TRAP_PC);
    interrupt_pending = 1'b0;
    tick();
    chk("irq_pulse_end", interrupt_taken, 0);
    tick();

    // ---- watchdog: stuck drain, reclear ignored outside IDLE
    interrupt_pending = 1'b1; inflight_count = 4'd1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 15) chk("wd_c15", drain_timeout, 0);
      if (k == 16) chk("wd_c16", drain_timeout, 1);
      if (k == 17) reclear_req = 1'b1;
      if (k == 18) begin
        reclear_req = 1'b0;
        chk("wd_reclr_ign_ic", init_clear, 0);
        chk("wd_reclr_ign_fh", fetch_hold, 1);
      end
      if (k == 20) chk("wd_sticky", drain_timeout, 1);
    end
    interrupt_pending = 1'b0; inflight_count = 4'd0;
    tick();
    chk("wd_idle_fetch", fetch_hold, 0);
    chk("wd_idle_sticky", drain_timeout, 1);
    reclear_req = 1'b1;
    clear_seq("reclr");

    // ---- asynchronous reset in the middle of DISCARD
    exc_valid = 4'b0110;
    tick();
    exc_valid = '0; inflight_count = 4'd2;
    tick();
    chk("ar_disc_issue", issue_hold, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_issue", issue_hold, 0);
    chk("ar_wb", wb_suppress, 0);
    chk("ar_fetch", fetch_hold, 0);
    chk("ar_pc", pc, RV);
    tick(); tick();
    chk("ar_held_ic", init_clear, 0);
    inflight_count = 4'd0;
    rst = 1'b1;
    clear_seq("rst2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gc_flush_ctrl.md
Name: gc_flush_ctrl

Overview:
- Parametrised global-control sequencer, successor of the single-source-table GC FSM.
- Arbitrates N exception sources by direct ID compare against the oldest in-flight ID.
- Serialises ifence, ret and interrupts through drain/flush/discard phases.
- Adds a runtime re-clear request and a sticky drain-timeout watchdog; drives fetch/issue/retire holds and the PC override into the front end.

Parameters:
NUM_SRC, 4, number of exception sources (1..8)
ID_W, 3, instruction ID width
CODE_W, 5, exception code width
CLEAR_DEPTH, 64, cycles spent in CLEAR (power of two, >=2)
DRAIN_TIMEOUT, 1024, DRAIN cycles before watchdog fires (0 disables)
RESET_VEC, 32'h8000_0000, PC issued after any clear

Ports:
clk  in  1  clock
rst  in  1  reset: one clock; reset is asynchronous and active-low
issue_valid  in  1  instruction issued this cycle
issue_is_ifence  in  1  issued op is FENCE.I
issue_is_ret  in  1  issued op is MRET/SRET
issue_pc_p4  in  32  PC+4 of issued op
ret_epc  in  32  return target
trap_target_pc  in  32  trap vector
exc_valid  in  NUM_SRC  per-source exception pending
exc_id  in  NUM_SRC*ID_W  per-source faulting ID
exc_code  in  NUM_SRC*CODE_W  per-source code
oldest_id  in  ID_W  next-to-retire ID
interrupt_pending  in  1  enabled interrupt pending
inflight_count  in  ID_W+1  post-issue instructions outstanding
sq_empty  in  1  store queue empty
reclear_req  in  1  request full re-initialisation
fetch_hold, issue_hold, retire_hold, wb_suppress, init_clear, pc_override  out  1 each  registered controls
pc  out  32  override target
exc_ack  out  NUM_SRC  one-hot ack of the winning source
trap_valid  out  1  exception taken (comb)
trap_code  out  CODE_W  winning code
interrupt_taken, ret_taken  out  1  pulses
drain_timeout  out  1  sticky watchdog flag

Behaviour:
- States RESET, CLEAR, IDLE, DRAIN, FLUSH, DISCARD. Reset enters RESET; all registered outputs 0, pc = RESET_VEC, drain_timeout 0.
- RESET -> CLEAR (1 cycle). CLEAR lasts exactly CLEAR_DEPTH cycles, then -> IDLE.
- Match: source i matches when exc_valid[i] & exc_id[i]==oldest_id. The lowest matching index wins. trap_valid = any match & state in {IDLE, DRAIN}. exc_ack is one-hot of the winner, gated by trap_valid.
- IDLE:
  - trap_valid -> FLUSH.
  - Else reclear_req -> CLEAR.
  - Else issue_valid & (ifence|ret), or interrupt_pending, or |exc_valid -> DRAIN. Op type and pc_p4 are latched on issue_valid.
- DRAIN: transition rules in priority order:
  1. trap_valid -> FLUSH.
  2. Latched op pending & inflight_count==0 & sq_empty -> FLUSH.
  3. interrupt_pending & inflight_count==0 -> FLUSH.
  4. No op, no interrupt, no exc_valid -> IDLE.
- Watchdog: counts DRAIN cycles. At DRAIN_TIMEOUT it sets drain_timeout, which stays set until a reclear or reset; the state is unaffected.
- FLUSH -> DISCARD (1 cycle).
- DISCARD -> IDLE when inflight_count==0 & sq_empty.
- Trap kind is decided on the FLUSH entry cycle, priority exception > op > interrupt:
  - interrupt_taken pulses only if no exception and no op.
  - ret_taken pulses for a ret op.
  - The latched op is cleared.
- Registered from next_state:
  - fetch_hold: CLEAR, DRAIN, FLUSH.
  - issue_hold: CLEAR, DRAIN, FLUSH, DISCARD.
  - retire_hold: FLUSH.
  - wb_suppress: CLEAR, DISCARD.
  - init_clear: CLEAR.
  - pc_override: FLUSH, or the final CLEAR cycle.
- pc is registered:
  - RESET_VEC during/after clear.
  - trap_target_pc on exception or interrupt.
  - latched pc_p4 for ifence.
  - ret_epc for ret.
- Async reset mid-sequence aborts immediately and restarts from RESET.
- reclear_req outside IDLE is ignored and not queued.

Test Plan:
- Release reset -> init_clear high cycles 2..65, pc_override 1 cycle at end with pc=32'h8000_0000, then IDLE.
- exc_valid=4'b0110, both IDs==oldest_id, codes 2 and 7 -> exc_ack=4'b0010, trap_code=2, pc=trap_target_pc, FLUSH then DISCARD.
- ifence issued with pc_p4=0x104, inflight_count=3 decrementing to 0 -> fetch_hold until flush, pc=0x104, no interrupt_taken.
- ret issued and interrupt_pending together -> ret_taken=1, interrupt_taken=0, pc=ret_epc.
- DRAIN_TIMEOUT=16, inflight_count stuck at 1 -> drain_timeout=1 on cycle 16 of DRAIN, sticky; reclear_req in IDLE clears it.
- Assert rst low mid-DISCARD -> all holds 0 asynchronously; the restart repeats the clear sequence.
